// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and DMA-command bundle between a UART receiver/host side and the
// command parser. The parser takes the slave modport.
interface uart_cmd_parser_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic [1:0]  o_uart_st;
    logic [31:0] o_uart_addr;
    logic [31:0] o_uart_len;
    logic        o_rx_valid;
    logic [7:0]  o_rx_data;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_uart_st, o_uart_addr, o_uart_len,
        output o_rx_valid, o_rx_data, o_err, o_err_code, o_busy
    );

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_uart_st, o_uart_addr, o_uart_len,
        input  o_rx_valid, o_rx_data, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes 55 AA-framed host commands into a DMA start strobe with address/length,
// then forwards exactly len payload bytes for write commands.
module uart_cmd_parser #(
    parameter int unsigned SYS_FRE    = 100,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic               i_sys_clk,
    input  logic               i_reset,
    uart_cmd_parser_if.slave   bus
);

    localparam logic [31:0] TO_CYC = 32'(SYS_FRE * TIMEOUT_US);
    // Fires two counts early so the registered o_err lands in gap cycle TO_CYC.
    localparam logic [31:0] TO_FIRE = TO_CYC - 32'd2;

    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;
    localparam logic [7:0] OP_WR = 8'h01;
    localparam logic [7:0] OP_RD = 8'h02;

    typedef enum logic [2:0] {IDLE, SYNC, HDR, CHK, ISSUE, PAY} state_t;

    state_t      r_state, w_next;
    logic [71:0] r_hdr;
    logic [3:0]  r_hdr_cnt;
    logic [7:0]  r_xor;
    logic [31:0] r_pay_cnt;
    logic [31:0] r_to_cnt;
    logic [1:0]  r_st;
    logic [31:0] r_addr, r_len;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_err, w_issue, w_fwd, w_hdr_clr, w_hdr_shift;
    logic [1:0]  w_err_code;
    logic        w_to_run, w_timeout;
    logic [7:0]  w_op;
    logic [31:0] w_hdr_addr, w_hdr_len;

    assign w_op       = r_hdr[71:64];
    assign w_hdr_addr = r_hdr[63:32];
    assign w_hdr_len  = r_hdr[31:0];

    assign w_to_run  = (r_state == SYNC) || (r_state == HDR) ||
                       (r_state == CHK)  || (r_state == PAY);
    assign w_timeout = w_to_run && !bus.i_rx_valid && (r_to_cnt == TO_FIRE);

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_next      = r_state;
        w_err       = 1'b0;
        w_err_code  = 2'd0;
        w_issue     = 1'b0;
        w_fwd       = 1'b0;
        w_hdr_clr   = 1'b0;
        w_hdr_shift = 1'b0;
        unique case (r_state)
            IDLE: if (bus.i_rx_valid && bus.i_rx_data == SYNC0) w_next = SYNC;
            SYNC: if (bus.i_rx_valid) begin
                if (bus.i_rx_data == SYNC1) begin
                    w_next    = HDR;
                    w_hdr_clr = 1'b1;
                end else if (bus.i_rx_data != SYNC0) begin
                    w_next = IDLE;
                end
            end
            HDR: if (bus.i_rx_valid) begin
                w_hdr_shift = 1'b1;
                if (r_hdr_cnt == 4'd8) w_next = CHK;
            end
            CHK: if (bus.i_rx_valid) begin
                w_next = IDLE;
                if (bus.i_rx_data != r_xor) begin
                    w_err = 1'b1;  w_err_code = 2'd1;
                end else if (w_op != OP_WR && w_op != OP_RD) begin
                    w_err = 1'b1;  w_err_code = 2'd2;
                end else if (w_hdr_len == 32'd0 || w_hdr_len[1:0] != 2'd0) begin
                    w_err = 1'b1;  w_err_code = 2'd3;
                end else begin
                    w_issue = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                // A byte landing in the strobe cycle is already write payload byte 0.
                w_fwd  = bus.i_rx_valid && (w_op == OP_WR);
                w_next = (w_op == OP_WR) ? PAY : IDLE;
            end
            PAY: if (bus.i_rx_valid) begin
                w_fwd = 1'b1;
                if (r_pay_cnt + 32'd1 == r_len) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next     = IDLE;
            w_err      = 1'b1;
            w_err_code = 2'd0;
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_hdr      <= '0;
            r_hdr_cnt  <= '0;
            r_xor      <= '0;
            r_pay_cnt  <= '0;
            r_to_cnt   <= '0;
            r_st       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            if (w_hdr_clr) begin
                r_hdr_cnt <= '0;
                r_xor     <= '0;
            end else if (w_hdr_shift) begin
                r_hdr     <= {r_hdr[63:0], bus.i_rx_data};
                r_hdr_cnt <= r_hdr_cnt + 4'd1;
                r_xor     <= r_xor ^ bus.i_rx_data;
            end

            r_st <= w_issue ? {w_op == OP_RD, 1'b1} : 2'b00;
            if (w_issue) begin
                r_addr    <= w_hdr_addr;
                r_len     <= w_hdr_len;
                r_pay_cnt <= '0;
            end else if (w_fwd) begin
                r_pay_cnt <= r_pay_cnt + 32'd1;
            end

            r_rx_valid <= w_fwd;
            if (w_fwd) r_rx_data <= bus.i_rx_data;

            r_err <= w_err;
            if (w_err) r_err_code <= w_err_code;

            // Gap counter restarts on every byte and on every state entry.
            if (!w_to_run || bus.i_rx_valid || w_next != r_state) r_to_cnt <= '0;
            else                                                  r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign bus.o_uart_st   = r_st;
    assign bus.o_uart_addr = r_addr;
    assign bus.o_uart_len  = r_len;
    assign bus.o_rx_valid  = r_rx_valid;
    assign bus.o_rx_data   = r_rx_data;
    assign bus.o_err       = r_err;
    assign bus.o_err_code  = r_err_code;
    assign bus.o_busy      = (r_state != IDLE);

endmodule
